// File: rtl/mult_pkg.sv
// Shared constants for the multiplier datapath: operand width, the split point of
// the final carry-propagate adder, and the partial-product count of the reduction tree.
package mult_pkg;

    localparam int MULT_W    = 64;
    localparam int CPA_SPLIT = 32;
    localparam int PP_COUNT  = 16;

endpackage

// File: rtl/cpa_slice.sv
// Purely combinational W-bit adder with carry-in and carry-out; one instance
// covers each half of the pipelined carry-propagate adder.
module cpa_slice #(
    parameter int W = 32
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         cin,
    output logic [W-1:0] sum,
    output logic         cout
);

    always_comb begin
        {cout, sum} = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
    end

endmodule

// File: rtl/cpa_pipe64.sv
// Final carry-propagate adder of the reduction tree: prod = sum + (carry << 1) mod 2^WIDTH,
// split into two registered halves with a valid/ready handshake and full backpressure.
module cpa_pipe64
    import mult_pkg::*;
#(
    parameter int WIDTH = MULT_W,
    parameter int SPLIT = CPA_SPLIT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] sum_i,
    input  logic [WIDTH-1:0] carry_i,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] prod_o,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             busy_o
);

    localparam int HI_W = WIDTH - SPLIT;

    logic [WIDTH-1:0] cs;
    logic [SPLIT-1:0] lo_sum;
    logic             lo_cout;
    logic [HI_W-1:0]  hi_sum;
    logic             hi_cout;
    logic [WIDTH:0]   s2_next;

    logic [SPLIT-1:0] s1_lo;
    logic             s1_c;
    logic [HI_W-1:0]  s1_hs;
    logic [HI_W-1:0]  s1_hc;
    logic             s1_v;
    logic [WIDTH-1:0] s2_res;
    logic             s2_v;

    logic s2_free;
    logic s1_adv;
    logic accept;

    // The carry row has weight i+1; its top bit falls off the end of the shift.
    assign cs = carry_i << 1;

    cpa_slice #(.W(SPLIT)) u_lo (
        .a    (sum_i[SPLIT-1:0]),
        .b    (cs[SPLIT-1:0]),
        .cin  (1'b0),
        .sum  (lo_sum),
        .cout (lo_cout)
    );

    cpa_slice #(.W(HI_W)) u_hi (
        .a    (s1_hs),
        .b    (s1_hc),
        .cin  (s1_c),
        .sum  (hi_sum),
        .cout (hi_cout)
    );

    // The overall carry-out is dropped: the result is modulo 2^WIDTH.
    assign s2_next = {hi_cout, hi_sum, s1_lo};

    assign s2_free  = !s2_v || out_ready;
    assign s1_adv   = s1_v && s2_free;
    assign in_ready = !s1_v || s1_adv;
    assign accept   = in_valid && in_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_lo <= '0;
            s1_c  <= 1'b0;
            s1_hs <= '0;
            s1_hc <= '0;
            s1_v  <= 1'b0;
        end else if (accept) begin
            s1_lo <= lo_sum;
            s1_c  <= lo_cout;
            s1_hs <= sum_i[WIDTH-1:SPLIT];
            s1_hc <= cs[WIDTH-1:SPLIT];
            s1_v  <= 1'b1;
        end else if (s1_adv) begin
            s1_v  <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_res <= '0;
            s2_v   <= 1'b0;
        end else if (s1_adv) begin
            s2_res <= WIDTH'(s2_next);
            s2_v   <= 1'b1;
        end else if (s2_v && out_ready) begin
            s2_v   <= 1'b0;
        end
    end

    assign prod_o    = s2_res;
    assign out_valid = s2_v;
    assign busy_o    = s1_v || s2_v;

endmodule

// File: tb/tb_cpa_pipe64.sv
// Scoreboard bench for cpa_pipe64: the driver pushes the arithmetic expectation on every
// accept, and an independent monitor pops and compares on every output handshake.
module tb_cpa_pipe64;
    import mult_pkg::*;

    localparam int W = MULT_W;

    typedef struct {
        logic [W-1:0] data;
        int           acc_cyc;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [W-1:0] sum_i = '0;
    logic [W-1:0] carry_i = '0;
    logic         in_valid = 1'b0;
    logic         out_ready = 1'b0;
    logic         in_ready;
    logic [W-1:0] prod_o;
    logic         out_valid;
    logic         busy_o;

    exp_t sb[$];
    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;
    bit   check_lat = 1'b0;

    cpa_pipe64 dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .sum_i     (sum_i),
        .carry_i   (carry_i),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .prod_o    (prod_o),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .busy_o    (busy_o)
    );

    initial forever #5 clk = ~clk;

    always @(posedge clk) cyc++;

    function automatic logic [W-1:0] ref_prod(input logic [W-1:0] s, input logic [W-1:0] c);
        logic [W-1:0] shifted;
        shifted = c * 2;
        return s + shifted;
    endfunction

    task automatic checkOutput(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic pushExpected(input logic [W-1:0] exp);
        exp_t e;
        e.data = exp;
        e.acc_cyc = cyc;
        sb.push_back(e);
    endtask

    // Offer one vector and hold it until accepted, bounded so a stuck in_ready cannot hang the run.
    task automatic applyStimulus(input logic [W-1:0] s, input logic [W-1:0] c, input logic [W-1:0] exp);
        int n;
        n = 0;
        @(negedge clk);
        sum_i = s;
        carry_i = c;
        in_valid = 1'b1;
        #1;
        while (!in_ready) begin
            if (n >= 200) begin
                checks++;
                failures++;
                $display("[TB] FAIL accept_timeout: in_ready stayed %b, expected 1", in_ready);
                in_valid = 1'b0;
                return;
            end
            @(negedge clk);
            #1;
            n++;
        end
        pushExpected(exp);
    endtask

    task automatic drain();
        int n;
        n = 0;
        @(negedge clk);
        in_valid = 1'b0;
        out_ready = 1'b1;
        while ((sb.size() != 0 || busy_o) && n < 200) begin
            @(negedge clk);
            n++;
        end
        #3;
        checkOutput("drain_queue", W'(sb.size()), '0);
        checkOutput("drain_busy", W'(busy_o), '0);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (rst_n && out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    checks++;
                    failures++;
                    $display("[TB] FAIL unexpected_output: got %h, expected no output", prod_o);
                end else begin
                    e = sb.pop_front();
                    checkOutput("prod_o", prod_o, e.data);
                    if (check_lat)
                        checkOutput("latency", W'(cyc - e.acc_cyc), W'(2));
                end
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("[TB] FAIL watchdog: simulation still running, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin : stimulus
        int accepted;
        int cycles;
        $display("[TB] final adder for a %0d-row reduction tree", PP_COUNT);

        #3;
        checkOutput("reset_out_valid", W'(out_valid), '0);
        checkOutput("reset_busy", W'(busy_o), '0);
        checkOutput("reset_prod", prod_o, '0);
        checkOutput("reset_in_ready", W'(in_ready), W'(1));
        @(negedge clk);
        rst_n = 1'b1;
        out_ready = 1'b1;

        // Carry crossing the split, then wrap-around and the dropped top carry bit.
        check_lat = 1'b1;
        applyStimulus(64'h0000_0000_FFFF_FFFF, 64'h1, 64'h0000_0001_0000_0001);
        applyStimulus(64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 64'h1);
        applyStimulus(64'h0, 64'h8000_0000_0000_0000, 64'h0);
        drain();

        // Full rate: every cycle both handshakes fire, so each result lands exactly two cycles on.
        for (int i = 0; i < 100; i++) begin
            logic [W-1:0] s;
            logic [W-1:0] c;
            s = {$urandom, $urandom};
            c = {$urandom, $urandom};
            applyStimulus(s, c, ref_prod(s, c));
        end
        drain();
        check_lat = 1'b0;

        // Backpressure: two entries fill the pipe, the third waits, output stays frozen.
        @(negedge clk);
        out_ready = 1'b0;
        sum_i = 64'd1;
        carry_i = '0;
        in_valid = 1'b1;
        #1;
        checkOutput("bp_ready_A", W'(in_ready), W'(1));
        pushExpected(64'd1);
        @(negedge clk);
        sum_i = 64'd2;
        #1;
        checkOutput("bp_ready_B", W'(in_ready), W'(1));
        pushExpected(64'd2);
        @(negedge clk);
        sum_i = 64'd3;
        #1;
        checkOutput("bp_ready_after_B", W'(in_ready), '0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            #1;
            checkOutput("bp_hold_valid", W'(out_valid), W'(1));
            checkOutput("bp_hold_prod", prod_o, 64'd1);
            checkOutput("bp_hold_ready", W'(in_ready), '0);
        end
        @(negedge clk);
        out_ready = 1'b1;
        #1;
        checkOutput("bp_ready_release", W'(in_ready), W'(1));
        pushExpected(64'd3);
        drain();

        // Random valid/ready toggling until 1000 vectors are accepted.
        accepted = 0;
        cycles = 0;
        while (accepted < 1000 && cycles < 8000) begin
            logic [W-1:0] s;
            logic [W-1:0] c;
            @(negedge clk);
            s = {$urandom, $urandom};
            c = {$urandom, $urandom};
            sum_i = s;
            carry_i = c;
            in_valid = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            #1;
            if (in_valid && in_ready) begin
                pushExpected(ref_prod(s, c));
                accepted++;
            end
            cycles++;
        end
        checkOutput("random_accepted", W'(accepted), W'(1000));
        drain();

        // Asynchronous reset with two entries in flight.
        @(negedge clk);
        out_ready = 1'b0;
        sum_i = 64'h1234_5678_9ABC_DEF0;
        carry_i = 64'h5;
        in_valid = 1'b1;
        @(negedge clk);
        sum_i = 64'h0FED_CBA9_8765_4321;
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        checkOutput("rst_busy_before", W'(busy_o), W'(1));
        checkOutput("rst_valid_before", W'(out_valid), W'(1));
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("rst_out_valid", W'(out_valid), '0);
        checkOutput("rst_busy", W'(busy_o), '0);
        checkOutput("rst_prod", prod_o, '0);
        checkOutput("rst_in_ready", W'(in_ready), W'(1));
        sb.delete();
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checkOutput("post_rst_in_ready", W'(in_ready), W'(1));
        checkOutput("post_rst_out_valid", W'(out_valid), '0);

        out_ready = 1'b1;
        applyStimulus(64'h0000_0000_FFFF_FFFF, 64'h1, 64'h0000_0001_0000_0001);
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule
